// File: rtl/lsu_arbiter.sv
// lsu_arbiter: two-port arbiter and sequencer in front of the load/store unit.
//
// Requester 0 is the core pipeline and requester 1 is the debug/loader port.
// Each transaction takes three cycles:
//   IDLE   - grant pulse, and the request is latched
//   ACCESS - the LSU is driven for one cycle and load data is captured
//   RESP   - rvalid pulse to the granted requester, with err and rdata
//
// Optional feature macro: LSU_ARB_RR_EN
//   defined   - round-robin on a tie, using a last-grant pointer that resets to 1
//   undefined - fixed priority, where requester 0 wins ties (no pointer)
//
// Ports (slot r of a packed per-requester bus is bits [r*W +: W]):
//   clk_i, rst_i     clock (rising edge), synchronous active-high reset
//   req_i[1:0]       request per requester, held until its gnt_o
//   we_i[1:0]        1 = store, 0 = load
//   func3_i[5:0]     RISC-V funct3 per requester
//   addr_i           2 x ADDR_W byte addresses
//   wdata_i          2 x DATA_W store data
//   gnt_o[1:0]       one-cycle accept pulse (one-hot or zero)
//   rvalid_o[1:0]    one-cycle response pulse
//   err_o            misaligned access, valid with rvalid_o
//   rdata_o          load data, valid with rvalid_o
//   lsu_st_en_o, lsu_func3_o, lsu_addr_o, lsu_st_data_o  LSU drive (ACCESS only)
//   lsu_ld_data_i    LSU load data, combinational from lsu_addr_o
module lsu_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          req_i,
    input  logic [1:0]          we_i,
    input  logic [5:0]          func3_i,
    input  logic [2*ADDR_W-1:0] addr_i,
    input  logic [2*DATA_W-1:0] wdata_i,
    output logic [1:0]          gnt_o,
    output logic [1:0]          rvalid_o,
    output logic                err_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                lsu_st_en_o,
    output logic [2:0]          lsu_func3_o,
    output logic [ADDR_W-1:0]   lsu_addr_o,
    output logic [DATA_W-1:0]   lsu_st_data_o,
    input  logic [DATA_W-1:0]   lsu_ld_data_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic                win;
    logic                take;
    logic                sel_we;
    logic [2:0]          sel_func3;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_mis;

    logic                lat_we;
    logic [2:0]          lat_func3;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                lat_idx;
    logic                lat_mis;
    logic [DATA_W-1:0]   rdata_q;

`ifdef LSU_ARB_RR_EN
    logic                last_gnt;
`endif

    // Winner selection: a single requester always wins; ties follow the build option.
    always_comb begin
        win = 1'b0;
        if (req_i == 2'b10) begin
            win = 1'b1;
        end else if (req_i == 2'b11) begin
`ifdef LSU_ARB_RR_EN
            win = ~last_gnt;
`else
            win = 1'b0;
`endif
        end
    end

    assign take      = (state == IDLE) && (|req_i) && !rst_i;
    assign sel_we    = we_i[win];
    assign sel_func3 = func3_i[win*3 +: 3];
    assign sel_addr  = addr_i[win*ADDR_W +: ADDR_W];
    assign sel_wdata = wdata_i[win*DATA_W +: DATA_W];

    // funct3[1:0]: 01 half needs addr[0]=0, 10 word needs addr[1:0]=0, 11 illegal.
    always_comb begin
        sel_mis = 1'b0;
        case (sel_func3[1:0])
            2'b01:   sel_mis = sel_addr[0];
            2'b10:   sel_mis = |sel_addr[1:0];
            2'b11:   sel_mis = 1'b1;
            default: sel_mis = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_func3 <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_idx   <= 1'b0;
            lat_mis   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                lat_we    <= sel_we;
                lat_func3 <= sel_func3;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
                lat_idx   <= win;
                lat_mis   <= sel_mis;
            end
            // Stores and misaligned accesses respond with zero data.
            if (state == ACCESS) begin
                rdata_q <= (lat_we || lat_mis) ? '0 : lsu_ld_data_i;
            end
        end
    end

`ifdef LSU_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt <= 1'b1;
        end else if (take) begin
            last_gnt <= win;
        end
    end
`endif

    always_comb begin
        state_next    = state;
        gnt_o         = '0;
        rvalid_o      = '0;
        err_o         = 1'b0;
        rdata_o       = '0;
        lsu_st_en_o   = 1'b0;
        lsu_func3_o   = '0;
        lsu_addr_o    = '0;
        lsu_st_data_o = '0;
        case (state)
            IDLE: begin
                if (take) begin
                    gnt_o[win] = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!lat_mis) begin
                    // Reset gates the write enable so a reset mid-access commits nothing.
                    lsu_st_en_o   = lat_we && !rst_i;
                    lsu_func3_o   = lat_func3;
                    lsu_addr_o    = lat_addr;
                    lsu_st_data_o = lat_wdata;
                end
                state_next = RESP;
            end
            RESP: begin
                if (!rst_i) begin
                    rvalid_o[lat_idx] = 1'b1;
                    err_o             = lat_mis;
                    rdata_o           = rdata_q;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: directed self-checking bench for lsu_arbiter.
// A small word-addressed memory stands in for the LSU: loads are combinational
// from lsu_addr_o and stores commit on the rising edge while lsu_st_en_o is high.
// Inputs are driven 2 time units after a rising edge and outputs are sampled 1 unit later.
module tb_lsu_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [5:0]  func3_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        lsu_st_en_o;
    logic [2:0]  lsu_func3_o;
    logic [31:0] lsu_addr_o;
    logic [31:0] lsu_st_data_o;
    logic [31:0] lsu_ld_data_i;

    int checks = 0;
    int passed = 0;
    int cycle  = 0;

    logic        mem_init;
    logic [31:0] mem [0:63];

    lsu_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .we_i          (we_i),
        .func3_i       (func3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .gnt_o         (gnt_o),
        .rvalid_o      (rvalid_o),
        .err_o         (err_o),
        .rdata_o       (rdata_o),
        .lsu_st_en_o   (lsu_st_en_o),
        .lsu_func3_o   (lsu_func3_o),
        .lsu_addr_o    (lsu_addr_o),
        .lsu_st_data_o (lsu_st_data_o),
        .lsu_ld_data_i (lsu_ld_data_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycle <= cycle + 1;

    // LSU model: mem[i] = 0x1000_0000 + i, except 0x10 -> DEADBEEF and 0x40 -> 0BAD0BAD.
    assign lsu_ld_data_i = mem[lsu_addr_o[7:2]];
    always @(posedge clk_i) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
            mem[4]  <= 32'hDEAD_BEEF;
            mem[16] <= 32'h0BAD_0BAD;
        end else if (lsu_st_en_o) begin
            mem[lsu_addr_o[7:2]] <= lsu_st_data_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic drive_req(input int r, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
        req_i[r]             = 1'b1;
        we_i[r]              = we;
        func3_i[r*3 +: 3]    = f3;
        addr_i[r*32 +: 32]   = a;
        wdata_i[r*32 +: 32]  = d;
    endtask

    task automatic clear_req();
        req_i = 2'b00;
    endtask

    task automatic test_reset();
        rst_i    = 1'b1;
        mem_init = 1'b1;
        req_i    = 2'b00;
        we_i     = 2'b00;
        func3_i  = '0;
        addr_i   = '0;
        wdata_i  = '0;
        tick();
        tick();
        drive_req(0, 1'b0, 3'b010, 32'h10, 32'h0);
        #1;
        checks++;
        if (gnt_o !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", gnt_o);
        else passed++;
        clear_req();
        mem_init = 1'b0;
        rst_i    = 1'b0;
        #1;
        checks++;
        if (rvalid_o !== 2'b00 || err_o !== 1'b0)
            $display("FAIL reset_resp: got rvalid=%b err=%b expected 00/0", rvalid_o, err_o);
        else passed++;
        checks++;
        if (rdata_o !== 32'h0) $display("FAIL reset_rdata: got %h expected 00000000", rdata_o);
        else passed++;
        checks++;
        if (lsu_st_en_o !== 1'b0 || lsu_addr_o !== 32'h0 || lsu_func3_o !== 3'b000 || lsu_st_data_o !== 32'h0)
            $display("FAIL reset_lsu: got en=%b addr=%h f3=%b data=%h expected all 0",
                     lsu_st_en_o, lsu_addr_o, lsu_func3_o, lsu_st_data_o);
        else passed++;
    endtask

    task automatic test_single_load();
        drive_req(0, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
        #1;
        checks++;
        if (gnt_o !== 2'b01) $display("FAIL load_gnt: got %b expected 01", gnt_o);
        else passed++;
        tick();
        clear_req();
        #1;
        checks++;
        if (lsu_addr_o !== 32'h10 || lsu_func3_o !== 3'b010 || lsu_st_en_o !== 1'b0)
            $display("FAIL load_access: got addr=%h f3=%b en=%b expected 00000010/010/0",
                     lsu_addr_o, lsu_func3_o, lsu_st_en_o);
        else passed++;
        tick();
        #1;
        checks++;
        if (rvalid_o !== 2'b01 || err_o !== 1'b0 || rdata_o !== 32'hDEAD_BEEF)
            $display("FAIL load_resp: got rvalid=%b err=%b rdata=%h expected 01/0/deadbeef",
                     rvalid_o, err_o, rdata_o);
        else passed++;
        tick();
        #1;
        checks++;
        if (rvalid_o !== 2'b00 || lsu_addr_o !== 32'h0)
            $display("FAIL load_idle: got rvalid=%b addr=%h expected 00/0", rvalid_o, lsu_addr_o);
        else passed++;
    endtask

    task automatic test_store_load();
        int en_cycles = 0;
        drive_req(1, 1'b1, 3'b010, 32'h20, 32'h1234_5678);
        #1;
        checks++;
        if (gnt_o !== 2'b10) $display("FAIL store_gnt: got %b expected 10", gnt_o);
        else passed++;
        if (lsu_st_en_o === 1'b1) en_cycles++;
        tick();
        clear_req();
        #1;
        if (lsu_st_en_o === 1'b1) en_cycles++;
        checks++;
        if (lsu_addr_o !== 32'h20 || lsu_st_data_o !== 32'h1234_5678)
            $display("FAIL store_access: got addr=%h data=%h expected 00000020/12345678",
                     lsu_addr_o, lsu_st_data_o);
        else passed++;
        tick();
        #1;
        if (lsu_st_en_o === 1'b1) en_cycles++;
        checks++;
        if (rvalid_o !== 2'b10 || err_o !== 1'b0 || rdata_o !== 32'h0)
            $display("FAIL store_resp: got rvalid=%b err=%b rdata=%h expected 10/0/0",
                     rvalid_o, err_o, rdata_o);
        else passed++;
        tick();
        drive_req(1, 1'b0, 3'b010, 32'h20, 32'h0);
        #1;
        if (lsu_st_en_o === 1'b1) en_cycles++;
        checks++;
        if (en_cycles != 1) $display("FAIL store_en_len: got %0d cycles expected 1", en_cycles);
        else passed++;
        checks++;
        if (gnt_o !== 2'b10) $display("FAIL reload_gnt: got %b expected 10", gnt_o);
        else passed++;
        tick();
        clear_req();
        tick();
        #1;
        checks++;
        if (rvalid_o !== 2'b10 || rdata_o !== 32'h1234_5678)
            $display("FAIL reload_resp: got rvalid=%b rdata=%h expected 10/12345678", rvalid_o, rdata_o);
        else passed++;
        tick();
    endtask

    task automatic test_misaligned();
        // LH at 0x21 from requester 0
        drive_req(0, 1'b0, 3'b001, 32'h21, 32'h0);
        tick();
        clear_req();
        #1;
        checks++;
        if (lsu_st_en_o !== 1'b0 || lsu_addr_o !== 32'h0 || lsu_func3_o !== 3'b000)
            $display("FAIL mis_lh_access: got en=%b addr=%h f3=%b expected 0/0/000",
                     lsu_st_en_o, lsu_addr_o, lsu_func3_o);
        else passed++;
        tick();
        #1;
        checks++;
        if (rvalid_o !== 2'b01 || err_o !== 1'b1 || rdata_o !== 32'h0)
            $display("FAIL mis_lh_resp: got rvalid=%b err=%b rdata=%h expected 01/1/0",
                     rvalid_o, err_o, rdata_o);
        else passed++;
        tick();
        // SW at 0x22 from requester 1
        drive_req(1, 1'b1, 3'b010, 32'h22, 32'hAAAA_5555);
        tick();
        clear_req();
        #1;
        checks++;
        if (lsu_st_en_o !== 1'b0 || lsu_addr_o !== 32'h0 || lsu_st_data_o !== 32'h0)
            $display("FAIL mis_sw_access: got en=%b addr=%h data=%h expected 0/0/0",
                     lsu_st_en_o, lsu_addr_o, lsu_st_data_o);
        else passed++;
        tick();
        #1;
        checks++;
        if (rvalid_o !== 2'b10 || err_o !== 1'b1 || rdata_o !== 32'h0)
            $display("FAIL mis_sw_resp: got rvalid=%b err=%b rdata=%h expected 10/1/0",
                     rvalid_o, err_o, rdata_o);
        else passed++;
        tick();
        checks++;
        if (mem[8] !== 32'h1234_5678 || mem[0] !== 32'h1000_0000)
            $display("FAIL mis_sw_nowrite: got mem8=%h mem0=%h expected 12345678/10000000", mem[8], mem[0]);
        else passed++;
    endtask

    task automatic test_contention();
        logic [1:0]  exp_gnt [4];
        logic [31:0] exp_data;
`ifdef LSU_ARB_RR_EN
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        drive_req(0, 1'b0, 3'b010, 32'h30, 32'h0);
        drive_req(1, 1'b0, 3'b010, 32'h34, 32'h0);
        for (int t = 0; t < 4; t++) begin
            exp_data = (exp_gnt[t] == 2'b01) ? 32'h1000_000C : 32'h1000_000D;
            #1;
            checks++;
            if (gnt_o !== exp_gnt[t]) $display("FAIL tie_gnt%0d: got %b expected %b", t, gnt_o, exp_gnt[t]);
            else passed++;
            tick();
            #1;
            checks++;
            if (gnt_o !== 2'b00) $display("FAIL tie_hold%0d: got gnt %b expected 00 in ACCESS", t, gnt_o);
            else passed++;
            tick();
            #1;
            checks++;
            if (rvalid_o !== exp_gnt[t] || rdata_o !== exp_data)
                $display("FAIL tie_resp%0d: got rvalid=%b rdata=%h expected %b/%h",
                         t, rvalid_o, rdata_o, exp_gnt[t], exp_data);
            else passed++;
            tick();
        end
        clear_req();
    endtask

    task automatic test_reset_mid();
        drive_req(0, 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D);
        tick();
        clear_req();
        rst_i = 1'b1;
        #1;
        checks++;
        if (lsu_st_en_o !== 1'b0) $display("FAIL rstmid_en: got %b expected 0", lsu_st_en_o);
        else passed++;
        tick();
        rst_i = 1'b0;
        #1;
        checks++;
        if (rvalid_o !== 2'b00 || lsu_st_en_o !== 1'b0)
            $display("FAIL rstmid_resp: got rvalid=%b en=%b expected 00/0", rvalid_o, lsu_st_en_o);
        else passed++;
        // An immediate grant shows the arbiter is back in IDLE.
        drive_req(0, 1'b0, 3'b010, 32'h40, 32'h0);
        #1;
        checks++;
        if (gnt_o !== 2'b01) $display("FAIL rstmid_idle: got gnt %b expected 01", gnt_o);
        else passed++;
        tick();
        clear_req();
        tick();
        #1;
        checks++;
        if (rvalid_o !== 2'b01 || rdata_o !== 32'h0BAD_0BAD)
            $display("FAIL rstmid_old: got rvalid=%b rdata=%h expected 01/0bad0bad", rvalid_o, rdata_o);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        int          last_gnt_cycle;
        logic [31:0] a;
        logic [31:0] exp_data;
        last_gnt_cycle = -1;
        drive_req(0, 1'b0, 3'b010, 32'h50, 32'h0);
        for (int t = 0; t < 4; t++) begin
            a        = 32'h50 + 32'(t * 4);
            exp_data = 32'h1000_0014 + 32'(t);
            #1;
            checks++;
            if (gnt_o !== 2'b01) $display("FAIL b2b_gnt%0d: got %b expected 01", t, gnt_o);
            else passed++;
            if (last_gnt_cycle >= 0) begin
                checks++;
                if (cycle - last_gnt_cycle != 3)
                    $display("FAIL b2b_gap%0d: got %0d cycles expected 3", t, cycle - last_gnt_cycle);
                else passed++;
            end
            last_gnt_cycle = cycle;
            tick();
            // Requester presents its next address right after the grant.
            addr_i[31:0] = a + 32'h4;
            #1;
            checks++;
            if (gnt_o !== 2'b00 || lsu_addr_o !== a)
                $display("FAIL b2b_access%0d: got gnt=%b addr=%h expected 00/%h", t, gnt_o, lsu_addr_o, a);
            else passed++;
            tick();
            #1;
            checks++;
            if (rvalid_o !== 2'b01 || rdata_o !== exp_data || gnt_o !== 2'b00)
                $display("FAIL b2b_resp%0d: got rvalid=%b rdata=%h gnt=%b expected 01/%h/00",
                         t, rvalid_o, rdata_o, gnt_o, exp_data);
            else passed++;
            tick();
        end
        clear_req();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_load();
        test_store_load();
        test_misaligned();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
